// File: rtl/vc_link_tx_pkg.sv
// vc_link_tx_pkg
//   Shared types and width helpers for the virtual-channel link transmitter.
//   flit_t       : flit carried on the link
//   credit_width : bits needed to hold a credit count in 0..size
//   id_width     : bits needed for a binary VC index in 0..n-1
package vc_link_tx_pkg;

    localparam int unsigned FLIT_W = 8;

    typedef logic [FLIT_W-1:0] flit_t;

    function automatic int unsigned credit_width(input int unsigned size);
        return (size < 1) ? 1 : $clog2(size + 1);
    endfunction

    function automatic int unsigned id_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/vc_link_tx_credit_counter.sv
// vc_credit_counter
//   Credit counter for one downstream VC buffer. Loads SIZE on reset,
//   decrements on a consumed credit, increments on a returned credit and
//   holds when both happen together. A return while full saturates and
//   raises a one-cycle overflow pulse.
//   clk     in  clock
//   rst_n   in  synchronous active-low reset
//   inc_i   in  credit returned
//   dec_i   in  credit consumed
//   count_o out current credit count
//   ovf_o   out overflow pulse (combinational, same cycle as the bad return)
module vc_credit_counter
    import vc_link_tx_pkg::*;
#(
    parameter  int unsigned SIZE = 3,
    localparam int unsigned CW   = credit_width(SIZE)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc_i,
    input  logic          dec_i,
    output logic [CW-1:0] count_o,
    output logic          ovf_o
);

    localparam logic [CW-1:0] FULL = CW'(SIZE);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        ovf_o   = 1'b0;
        if (inc_i && !dec_i) begin
            if (count_q == FULL) begin
                ovf_o = 1'b1;
            end else begin
                count_d = count_q + CW'(1);
            end
        end else if (dec_i && !inc_i) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= FULL;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/vc_link_tx.sv
// vc_link_tx
//   Credit-based virtual-channel link transmitter. Accepts one flit per cycle
//   when its target VC has a credit and, for head flits, the VC is not owned
//   by an open packet. Tracks per-VC credits and ownership, forwards accepted
//   flits onto the link and keeps sticky error flags.
//   Build option: define VC_LINK_TX_OUTPUT_REG_EN to register the link
//   outputs (1-cycle latency); otherwise they are combinational (0-cycle).
//   clk, rst_n       : clock, synchronous active-low reset
//   in_valid/in_ready: upstream handshake; in_vc, in_head, in_tail, in_data
//   credit_in        : per-VC credit return (downstream pop)
//   link_push/link_vc_id/link_data : flit toward downstream VC buffers
//   vc_credits, vc_busy            : per-VC credit count and ownership
//   err_credit_ovf, err_no_owner   : sticky error flags
module vc_link_tx
    import vc_link_tx_pkg::*;
#(
    parameter  int unsigned N    = 4,
    parameter  int unsigned SIZE = 3,
    parameter  type         fifo_elements_t = flit_t,
    localparam int unsigned VW   = id_width(N),
    localparam int unsigned CW   = credit_width(SIZE)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [VW-1:0]          in_vc,
    input  logic                   in_head,
    input  logic                   in_tail,
    input  fifo_elements_t         in_data,
    output logic                   in_ready,
    input  logic [N-1:0]           credit_in,
    output logic                   link_push,
    output logic [VW-1:0]          link_vc_id,
    output fifo_elements_t         link_data,
    output logic [N-1:0][CW-1:0]   vc_credits,
    output logic [N-1:0]           vc_busy,
    output logic                   err_credit_ovf,
    output logic                   err_no_owner
);

    logic [N-1:0][CW-1:0] cnt;
    logic [N-1:0]         ovf;
    logic [N-1:0]         dec;
    logic [N-1:0]         busy_q, busy_d;
    logic                 err_ovf_q, err_ovf_d;
    logic                 err_own_q, err_own_d;
    logic                 vc_ok;
    logic                 sel_has_credit;
    logic                 sel_busy;
    logic                 accept;

    // Guards against an in_vc beyond N-1 when N is not a power of two.
    assign vc_ok          = (32'(in_vc) < N);
    assign sel_has_credit = vc_ok && (cnt[in_vc] != '0);
    assign sel_busy       = vc_ok && busy_q[in_vc];

    // Uses registered credits only, so a same-cycle credit return does not bypass.
    assign in_ready = rst_n && sel_has_credit && !(in_head && sel_busy);
    assign accept   = in_valid && in_ready;

    for (genvar v = 0; v < N; v++) begin : g_vc
        assign dec[v] = accept && (in_vc == VW'(v));

        vc_credit_counter #(
            .SIZE (SIZE)
        ) u_cnt (
            .clk     (clk),
            .rst_n   (rst_n),
            .inc_i   (credit_in[v]),
            .dec_i   (dec[v]),
            .count_o (cnt[v]),
            .ovf_o   (ovf[v])
        );
    end

    always_comb begin
        busy_d    = busy_q;
        err_own_d = err_own_q;
        err_ovf_d = err_ovf_q | (|ovf);
        if (accept) begin
            if (!in_head && !busy_q[in_vc]) begin
                err_own_d = 1'b1;
            end
            // Tail wins over head so a single-flit packet leaves the VC free.
            if (in_tail) begin
                busy_d[in_vc] = 1'b0;
            end else if (in_head) begin
                busy_d[in_vc] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q    <= '0;
            err_ovf_q <= 1'b0;
            err_own_q <= 1'b0;
        end else begin
            busy_q    <= busy_d;
            err_ovf_q <= err_ovf_d;
            err_own_q <= err_own_d;
        end
    end

    assign vc_credits     = cnt;
    assign vc_busy        = busy_q;
    assign err_credit_ovf = err_ovf_q;
    assign err_no_owner   = err_own_q;

`ifdef VC_LINK_TX_OUTPUT_REG_EN
    logic           push_q;
    logic [VW-1:0]  vc_q;
    fifo_elements_t data_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            push_q <= 1'b0;
            vc_q   <= '0;
            data_q <= '0;
        end else begin
            push_q <= accept;
            vc_q   <= in_vc;
            data_q <= in_data;
        end
    end

    assign link_push  = push_q;
    assign link_vc_id = vc_q;
    assign link_data  = data_q;
`else
    assign link_push  = accept;
    assign link_vc_id = rst_n ? in_vc : '0;
    assign link_data  = in_data;
`endif

endmodule

// File: tb/tb_vc_link_tx.sv
module tb_vc_link_tx;
    import vc_link_tx_pkg::*;

`ifdef VC_LINK_TX_OUTPUT_REG_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif
    localparam int NV   = 4;
    localparam int SZ   = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic [1:0]      in_vc;
    logic            in_head;
    logic            in_tail;
    flit_t           in_data;
    logic            in_ready;
    logic [3:0]      credit_in;
    logic            link_push;
    logic [1:0]      link_vc_id;
    flit_t           link_data;
    logic [3:0][1:0] vc_credits;
    logic [3:0]      vc_busy;
    logic            err_credit_ovf;
    logic            err_no_owner;

    vc_link_tx #(
        .N    (NV),
        .SIZE (SZ)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_vc          (in_vc),
        .in_head        (in_head),
        .in_tail        (in_tail),
        .in_data        (in_data),
        .in_ready       (in_ready),
        .credit_in      (credit_in),
        .link_push      (link_push),
        .link_vc_id     (link_vc_id),
        .link_data      (link_data),
        .vc_credits     (vc_credits),
        .vc_busy        (vc_busy),
        .err_credit_ovf (err_credit_ovf),
        .err_no_owner   (err_no_owner)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Reference model state, expressed as plain counts and flags.
    int    m_cred [NV];
    bit    m_busy [NV];
    bit    m_ovf, m_own;
    bit    m_rpush, m_rzero;
    int    m_rvc;
    flit_t m_rdata;

    typedef struct {
        bit         rst_n;
        bit         valid;
        bit [1:0]   vc;
        bit         head;
        bit         tail;
        bit [7:0]   data;
        bit [3:0]   credit;
        bit         ready;
        int         cred;
        bit [3:0]   busy;
    } vec_t;

    vec_t tbl[26];

    function automatic vec_t mk(bit r, bit v, bit [1:0] vc, bit h, bit t, bit [7:0] d,
                                bit [3:0] cr, bit rdy, int cred, bit [3:0] busy);
        vec_t x;
        x.rst_n = r; x.valid = v; x.vc = vc; x.head = h; x.tail = t; x.data = d;
        x.credit = cr; x.ready = rdy; x.cred = cred; x.busy = busy;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit r, input bit v, input bit [1:0] vc, input bit h,
                         input bit t, input bit [7:0] d, input bit [3:0] cr);
        rst_n = r; in_valid = v; in_vc = vc; in_head = h; in_tail = t;
        in_data = d; credit_in = cr;
    endtask

    // Compares DUT against the model for the current (settled) inputs, then
    // advances the model and the clock by one cycle. Called mid low phase.
    task automatic cycle();
        bit    rdy, acc, dcr, inc, exp_push, exp_zero;
        int    exp_vc;
        flit_t exp_data;
        rdy = rst_n && (m_cred[in_vc] > 0) && !(in_head && m_busy[in_vc]);
        acc = in_valid && rdy;
        exp_push = (LAT != 0) ? m_rpush : acc;
        exp_zero = (LAT != 0) ? m_rzero : !rst_n;
        exp_vc   = (LAT != 0) ? m_rvc   : int'(in_vc);
        exp_data = (LAT != 0) ? m_rdata : in_data;
        if (chk_en) begin
            check("in_ready", in_ready, rdy);
            for (int v = 0; v < NV; v++) begin
                check($sformatf("vc_credits[%0d]", v), vc_credits[v], m_cred[v]);
                check($sformatf("vc_busy[%0d]", v), vc_busy[v], m_busy[v]);
            end
            check("err_credit_ovf", err_credit_ovf, m_ovf);
            check("err_no_owner", err_no_owner, m_own);
            check("link_push", link_push, exp_push);
            if (exp_push) begin
                check("link_vc_id", link_vc_id, exp_vc);
                check("link_data", link_data, exp_data);
            end else if (exp_zero) begin
                check("link_vc_id_reset", link_vc_id, 0);
            end
        end
        if (!rst_n) begin
            for (int v = 0; v < NV; v++) begin
                m_cred[v] = SZ;
                m_busy[v] = 1'b0;
            end
            m_ovf = 0; m_own = 0;
            m_rpush = 0; m_rvc = 0; m_rdata = '0; m_rzero = 1;
        end else begin
            for (int v = 0; v < NV; v++) begin
                dcr = acc && (int'(in_vc) == v);
                inc = credit_in[v];
                if (inc && !dcr && m_cred[v] == SZ) m_ovf = 1;
                else m_cred[v] = m_cred[v] + int'(inc) - int'(dcr);
            end
            if (acc) begin
                if (!in_head && !m_busy[in_vc]) m_own = 1;
                if (in_tail) m_busy[in_vc] = 0;
                else if (in_head) m_busy[in_vc] = 1;
            end
            m_rpush = acc; m_rvc = int'(in_vc); m_rdata = in_data; m_rzero = 0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        bit    prev_push, cur_push, tbl_push;
        int    got_vc;
        flit_t got_data;

        tbl[0]  = mk(1,1,2,1,1,8'h01,4'b0000,1,3,4'b0000);
        tbl[1]  = mk(1,1,2,1,1,8'h02,4'b0000,1,2,4'b0000);
        tbl[2]  = mk(1,1,2,1,1,8'h03,4'b0000,1,1,4'b0000);
        tbl[3]  = mk(1,1,2,1,1,8'h04,4'b0000,0,0,4'b0000);
        tbl[4]  = mk(1,1,2,1,1,8'h04,4'b0100,0,0,4'b0000);
        tbl[5]  = mk(1,1,2,1,1,8'h04,4'b0000,1,1,4'b0000);
        tbl[6]  = mk(1,1,1,1,1,8'h10,4'b0000,1,3,4'b0000);
        tbl[7]  = mk(1,1,1,1,1,8'h11,4'b0000,1,2,4'b0000);
        tbl[8]  = mk(1,1,1,1,1,8'h12,4'b0010,1,1,4'b0000);
        tbl[9]  = mk(1,0,1,0,0,8'h00,4'b0100,1,1,4'b0000);
        tbl[10] = mk(0,0,0,0,0,8'h00,4'b0000,0,3,4'b0000);
        tbl[11] = mk(1,1,0,1,0,8'h20,4'b0000,1,3,4'b0000);
        tbl[12] = mk(1,1,0,1,0,8'h21,4'b0000,0,2,4'b0001);
        tbl[13] = mk(1,1,3,1,0,8'h30,4'b0000,1,3,4'b0001);
        tbl[14] = mk(1,1,0,0,1,8'h22,4'b0000,1,2,4'b1001);
        tbl[15] = mk(1,1,0,1,0,8'h21,4'b0000,1,1,4'b1000);
        tbl[16] = mk(1,1,1,1,0,8'h40,4'b0000,1,3,4'b1001);
        tbl[17] = mk(1,1,1,0,0,8'h41,4'b0000,1,2,4'b1011);
        tbl[18] = mk(1,1,1,0,0,8'h42,4'b0000,1,1,4'b1011);
        tbl[19] = mk(1,1,1,0,0,8'h43,4'b0000,0,0,4'b1011);
        tbl[20] = mk(0,1,1,0,0,8'h43,4'b0000,0,0,4'b1011);
        tbl[21] = mk(1,0,1,0,0,8'h00,4'b0000,1,3,4'b0000);
        tbl[22] = mk(1,0,3,0,0,8'h00,4'b1000,1,3,4'b0000);
        tbl[23] = mk(1,0,3,0,0,8'h00,4'b0000,1,3,4'b0000);
        tbl[24] = mk(1,1,2,1,1,8'hA5,4'b0000,1,3,4'b0000);
        tbl[25] = mk(1,0,2,0,0,8'h00,4'b0000,1,2,4'b0000);

        drive(0,0,0,0,0,8'h00,4'b0000);
        @(negedge clk);
        #2;
        cycle();
        chk_en = 1'b1;
        #2;
        cycle();

        // Directed scenarios with hand-derived expectations.
        prev_push = 1'b0;
        for (int i = 0; i < 26; i++) begin
            drive(tbl[i].rst_n, tbl[i].valid, tbl[i].vc, tbl[i].head, tbl[i].tail,
                  tbl[i].data, tbl[i].credit);
            #2;
            cur_push = tbl[i].rst_n && tbl[i].valid && tbl[i].ready;
            tbl_push = (LAT != 0) ? prev_push : cur_push;
            check($sformatf("tbl%0d.in_ready", i), in_ready, tbl[i].ready);
            check($sformatf("tbl%0d.vc_credits", i), vc_credits[tbl[i].vc], tbl[i].cred);
            check($sformatf("tbl%0d.vc_busy", i), vc_busy, tbl[i].busy);
            check($sformatf("tbl%0d.link_push", i), link_push, tbl_push);
            prev_push = cur_push;
            cycle();
        end

        // Link latency for a single accept of 0xA5 on VC2.
        got_vc = -1; got_data = '0;
        drive(1,1,2,1,1,8'hA5,4'b0000);
        #2;
        check("lat_push_cycle0", link_push, (LAT == 0));
        if (link_push) begin got_vc = int'(link_vc_id); got_data = link_data; end
        cycle();
        drive(1,0,0,0,0,8'h00,4'b0000);
        #2;
        check("lat_push_cycle1", link_push, (LAT != 0));
        if (link_push) begin got_vc = int'(link_vc_id); got_data = link_data; end
        check("lat_vc_id", got_vc, 2);
        check("lat_data", got_data, 8'hA5);
        cycle();

        // Sticky overflow flag survives later traffic until reset.
        drive(1,0,3,0,0,8'h00,4'b1000);
        #2;
        cycle();
        drive(1,1,3,1,1,8'h77,4'b0000);
        #2;
        cycle();
        drive(1,0,0,0,0,8'h00,4'b0000);
        #2;
        check("ovf_sticky", err_credit_ovf, 1);
        cycle();

        // Randomized traffic against the model.
        for (int c = 0; c < 2000; c++) begin
            bit [3:0] cr;
            for (int v = 0; v < NV; v++) cr[v] = ($urandom_range(0, 3) == 0);
            drive(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0),
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 8'($urandom), cr);
            #2;
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
